// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - write/read/status bundle for regfile_param
// Signals:
//   W_en, W_Addr, WR : write port, driven by the master
//   R_Addr, S_Addr   : read addresses, driven by the master
//   R, S             : read data, driven by the slave
//   Busy             : clear-in-progress status, driven by the slave
interface regfile_param_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
);
  logic             W_en;
  logic [AW-1:0]    W_Addr;
  logic [WIDTH-1:0] WR;
  logic [AW-1:0]    R_Addr;
  logic [AW-1:0]    S_Addr;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] S;
  logic             Busy;

  modport master (
    output W_en, W_Addr, WR, R_Addr, S_Addr,
    input  R, S, Busy
  );

  modport slave (
    input  W_en, W_Addr, WR, R_Addr, S_Addr,
    output R, S, Busy
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 1-write/2-read register file with post-reset clear sequencer
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   Clk   : clock, all state changes on the rising edge
//   Reset : asynchronous active-high reset
//   bus   : regfile_param_if.slave (W_en/W_Addr/WR write port, R_Addr/R and
//           S_Addr/S combinational read ports, Busy clear status)
module regfile_param #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  regfile_param_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam bit            ZERO_EN   = (ZERO_R0 != 0);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          busy_q, busy_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] r_data, s_data;

  // Clear sequencer: one entry per edge, READY on the edge that clears the last entry.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Single array write port shared by the sequencer and the host; host
  // writes are dropped (not queued) while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.W_Addr;
    mem_wdata = bus.WR;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (bus.W_en && !(ZERO_EN && (bus.W_Addr == '0))) begin
      mem_we = 1'b1;
    end
    if (Reset) begin
      mem_we = 1'b0;
    end
  end

  // Array contents are deliberately not reset; the sequencer zeroes them.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: forwarding first, then the zero register and not-ready
  // masks override it so neither can leak a forwarded value.
  always_comb begin
    r_data = mem_q[bus.R_Addr];
    s_data = mem_q[bus.S_Addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.W_en && (bus.W_Addr == bus.R_Addr)) begin
      r_data = bus.WR;
    end
    if (bus.W_en && (bus.W_Addr == bus.S_Addr)) begin
      s_data = bus.WR;
    end
`endif
    if (ZERO_EN && (bus.R_Addr == '0)) begin
      r_data = '0;
    end
    if (ZERO_EN && (bus.S_Addr == '0)) begin
      s_data = '0;
    end
    if (state_q != ST_READY) begin
      r_data = '0;
      s_data = '0;
    end
  end

  assign bus.R    = r_data;
  assign bus.S    = s_data;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param
module tb_regfile_param;
  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_param_if #(.WIDTH(WIDTH), .AW(AW)) bus_n ();
  regfile_param_if #(.WIDTH(WIDTH), .AW(AW)) bus_z ();

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(0)) dut_n (
    .Clk(clk), .Reset(rst), .bus(bus_n)
  );
  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(1)) dut_z (
    .Clk(clk), .Reset(rst), .bus(bus_z)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents per variant plus edges of clearing left.
  logic [63:0] mem_n [DEPTH];
  logic [63:0] mem_z [DEPTH];
  int          clear_left;

  logic          in_we;
  logic [AW-1:0] in_wa, in_ra, in_sa;
  logic [63:0]   in_wd;

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [63:0]   wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] sa;
    logic [63:0]   er;
    logic [63:0]   es;
  } vec_t;
  vec_t tbl [8];

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [63:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] sa);
    in_we = we; in_wa = wa; in_wd = wd; in_ra = ra; in_sa = sa;
    bus_n.W_en = we; bus_n.W_Addr = wa; bus_n.WR = wd; bus_n.R_Addr = ra; bus_n.S_Addr = sa;
    bus_z.W_en = we; bus_z.W_Addr = wa; bus_z.WR = wd; bus_z.R_Addr = ra; bus_z.S_Addr = sa;
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      mem_n[i] = '0;
      mem_z[i] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      if (clear_left > 0) clear_left--;
      else if (in_we) begin
        mem_n[in_wa] = in_wd;
        if (in_wa != '0) mem_z[in_wa] = in_wd;
      end
    end
  endtask

  function automatic logic [63:0] exp_read(input bit zero, input logic [AW-1:0] addr);
    if (rst || clear_left > 0) return '0;
    if (zero && addr == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (in_we && in_wa == addr) return in_wd;
`endif
    return zero ? mem_z[addr] : mem_n[addr];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_busy;
    exp_busy = rst || (clear_left > 0);
    check({tag, "_busy_n"}, 64'(bus_n.Busy), 64'(exp_busy));
    check({tag, "_busy_z"}, 64'(bus_z.Busy), 64'(exp_busy));
    check({tag, "_r_n"}, bus_n.R, exp_read(1'b0, in_ra));
    check({tag, "_s_n"}, bus_n.S, exp_read(1'b0, in_sa));
    check({tag, "_r_z"}, bus_z.R, exp_read(1'b1, in_ra));
    check({tag, "_s_z"}, bus_z.S, exp_read(1'b1, in_sa));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Runs from reset release until Busy falls; optionally pokes writes
  // at clear cycle 5 and on the final clear edge (both must be dropped).
  task automatic wait_clear(input bit inject, output int n);
    n = 0;
    while (1) begin
      if (inject && n == 5) drive(1'b1, AW'(3), 64'hFF, AW'(3), AW'(0));
      else if (inject && n == 6) drive(1'b0, '0, '0, AW'(3), AW'(0));
      else if (inject && n == 31) drive(1'b1, AW'(9), 64'hBAD, AW'(9), AW'(3));
      #1;
      check_all("clear");
      tick();
      n++;
      if (!bus_n.Busy) break;
      if (n >= 100) begin
        check("clear_timeout", 64'(n), 64'(DEPTH));
        break;
      end
    end
    drive(1'b0, '0, '0, '0, '0);
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, AW'(a), AW'(DEPTH - 1 - a));
      #1;
      check("sweep_r", bus_n.R, 64'h0);
      check("sweep_s", bus_n.S, 64'h0);
      check_all("sweep");
      tick();
    end
  endtask

  initial begin
    int n;
    logic [63:0] exp_bp;

    tbl[0] = '{1'b1, AW'(7),  64'hDEADBEEF_CAFEF00D, AW'(3),  AW'(0),  64'h0, 64'h0};
    tbl[1] = '{1'b1, AW'(31), 64'h1,                 AW'(7),  AW'(3),  64'hDEADBEEF_CAFEF00D, 64'h0};
    tbl[2] = '{1'b0, AW'(0),  64'h0,                 AW'(7),  AW'(31), 64'hDEADBEEF_CAFEF00D, 64'h1};
    tbl[3] = '{1'b1, AW'(0),  64'h55,                AW'(31), AW'(31), 64'h1, 64'h1};
    tbl[4] = '{1'b1, AW'(12), 64'h01234567_89ABCDEF, AW'(0),  AW'(7),  64'h55, 64'hDEADBEEF_CAFEF00D};
    tbl[5] = '{1'b1, AW'(7),  64'hFFFFFFFF_FFFFFFFF, AW'(12), AW'(0),  64'h01234567_89ABCDEF, 64'h55};
    tbl[6] = '{1'b0, AW'(0),  64'h0,                 AW'(7),  AW'(12), 64'hFFFFFFFF_FFFFFFFF, 64'h01234567_89ABCDEF};
    tbl[7] = '{1'b0, AW'(0),  64'h0,                 AW'(31), AW'(0),  64'h1, 64'h55};

    drive(1'b0, '0, '0, AW'(5), AW'(6));
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all("reset_async");
    tick();
    tick();
    check_all("reset_hold");

    // First clear, with writes attempted during it and on its last edge.
    rst = 1'b0;
    wait_clear(1'b1, n);
    check("clear_len", 64'(n), 64'(DEPTH));
    sweep_zero();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].sa);
      #1;
      check("tbl_r", bus_n.R, tbl[i].er);
      check("tbl_s", bus_n.S, tbl[i].es);
      check_all("tbl");
      tick();
    end

    // Write and both reads on reg 4 (holding 0) in the same cycle.
`ifdef REGFILE_BYPASS_EN
    exp_bp = 64'hA5;
`else
    exp_bp = 64'h0;
`endif
    drive(1'b1, AW'(4), 64'hA5, AW'(4), AW'(4));
    #1;
    check("bypass_pre_r", bus_n.R, exp_bp);
    check("bypass_pre_s", bus_n.S, exp_bp);
    check_all("bypass_pre");
    tick();
    drive(1'b0, '0, '0, AW'(4), AW'(4));
    #1;
    check("bypass_post_r", bus_n.R, 64'hA5);
    check("bypass_post_s", bus_n.S, 64'hA5);
    check_all("bypass_post");
    tick();

    // Zero register: write to reg 0 with both reads on reg 0.
    drive(1'b1, AW'(0), 64'h77, AW'(0), AW'(0));
    #1;
    check("zero_pre_r", bus_z.R, 64'h0);
    check("zero_pre_s", bus_z.S, 64'h0);
    check_all("zero_pre");
    tick();
    drive(1'b0, '0, '0, AW'(0), AW'(0));
    #1;
    check("zero_post_r", bus_z.R, 64'h0);
    check("zero_post_s", bus_z.S, 64'h0);
    check("zero_plain_r", bus_n.R, 64'h77);
    check_all("zero_post");
    tick();

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra, sa;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      sa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, ra, sa);
      #1;
      check_all("rand");
      tick();
    end

    // Reset while READY: outputs drop at once, without a clock edge.
    drive(1'b0, '0, '0, AW'(7), AW'(31));
    #1;
    check_all("pre_rst");
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_ready_r", bus_n.R, 64'h0);
    check_all("rst_ready");
    tick();

    // Reset again ten edges into the clear; the full clear must repeat.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_all("mid_clear");
      tick();
    end
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_clear_rst");
    tick();
    rst = 1'b0;
    wait_clear(1'b0, n);
    check("reclear_len", 64'(n), 64'(DEPTH));
    sweep_zero();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
